// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and constants for the UART receive FIFO
package uart_rx_fifo_pkg;

    typedef logic [7:0] UartByte_t;

    localparam int UART_FIFO_DEPTH = 64;

    typedef struct packed {
        logic      valid;
        UartByte_t data;
    } UartStream_t;

    // EMPTY: nothing held; PRIMED: only the output holds a byte; STREAMING: RAM also holds bytes
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_PRIMED    = 2'd1,
        ST_STREAMING = 2'd2
    } FifoState_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side, parser-side and status signals of the receive FIFO
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
);
    logic                   dataReady;
    UartByte_t              data;
    logic                   outValid;
    UartByte_t              outData;
    logic                   outReady;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [15:0]            dropCount;
    logic                   flowStop;

    modport master (
        input  dataReady, data, outReady,
        output outValid, outData, count, overflow, dropCount, flowStop
    );

    modport slave (
        output dataReady, data, outReady,
        input  outValid, outData, count, overflow, dropCount, flowStop
    );
endinterface

// File: rtl/uart_rx_fifo_byte_fifo_ram.sv
// rtl/uart_rx_fifo_byte_fifo_ram.sv - DEPTH x 8 simple dual-port RAM with synchronous read
module byte_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  UartByte_t                wrData,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output UartByte_t                rdData
);
    UartByte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wrAddr] <= wrData;
    end

    // Read data only moves when re is set, so a stalled consumer sees it hold.
    always_ff @(posedge clk) begin
        if (re) rdData <= mem[rdAddr];
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with show-ahead valid/ready output
// Define UART_FLOW_CTRL_EN to drive flowStop from HIGH_WATER/LOW_WATER hysteresis.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int HIGH_WATER = 48,
    parameter int LOW_WATER  = 16
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    FifoState_t    state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [AW-1:0] wrPtr, rdPtr;
    UartByte_t     outReg, ramQ;
    logic          sel;
    logic          overflow;
    logic [15:0]   dropCount;
    logic          pushEv, popEv, dropEv, ramWe, ramRe, loadOut;
    UartStream_t   head;

    always_comb begin
        popEv     = (state != ST_EMPTY) && bus.outReady;
        pushEv    = bus.dataReady && ((count != FULL_LVL) || popEv);
        dropEv    = bus.dataReady && !pushEv;
        stateNext = state;
        ramWe     = 1'b0;
        ramRe     = 1'b0;
        loadOut   = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (pushEv) begin
                    loadOut   = 1'b1;
                    stateNext = ST_PRIMED;
                end
            end
            ST_PRIMED: begin
                // With the RAM empty a push that coincides with a pop bypasses it.
                if (popEv && pushEv) begin
                    loadOut = 1'b1;
                end else if (popEv) begin
                    stateNext = ST_EMPTY;
                end else if (pushEv) begin
                    ramWe     = 1'b1;
                    stateNext = ST_STREAMING;
                end
            end
            ST_STREAMING: begin
                ramWe = pushEv;
                ramRe = popEv;
                if (popEv && !pushEv && count == TWO) stateNext = ST_PRIMED;
            end
            default: stateNext = ST_EMPTY;
        endcase

        countNext = count;
        if (pushEv && !popEv)      countNext = count + ONE;
        else if (popEv && !pushEv) countNext = count - ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            outReg    <= '0;
            sel       <= 1'b0;
            overflow  <= 1'b0;
            dropCount <= '0;
        end else begin
            count <= countNext;
            if (ramWe) wrPtr <= wrPtr + AW'(1);
            // A read issued alongside a pop lands in ramQ for the very next cycle.
            if (ramRe) begin
                rdPtr <= rdPtr + AW'(1);
                sel   <= 1'b1;
            end
            if (loadOut) begin
                outReg <= bus.data;
                sel    <= 1'b0;
            end
            if (dropEv) begin
                overflow <= 1'b1;
                if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
            end
        end
    end

    byte_fifo_ram #(.DEPTH(DEPTH)) ram (
        .clk    (clk),
        .we     (ramWe),
        .wrAddr (wrPtr),
        .wrData (bus.data),
        .re     (ramRe),
        .rdAddr (rdPtr),
        .rdData (ramQ)
    );

    always_comb begin
        head.valid = (state != ST_EMPTY);
        head.data  = sel ? ramQ : outReg;
    end

    assign bus.outValid  = head.valid;
    assign bus.outData   = head.data;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign bus.dropCount = dropCount;

`ifdef UART_FLOW_CTRL_EN
    localparam logic [CW-1:0] HIGH_LVL = CW'(HIGH_WATER);
    localparam logic [CW-1:0] LOW_LVL  = CW'(LOW_WATER);
    logic flowStop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        flowStop <= 1'b0;
        else if (countNext >= HIGH_LVL)  flowStop <= 1'b1;
        else if (countNext <= LOW_LVL)   flowStop <= 1'b0;
    end

    assign bus.flowStop = flowStop;
`else
    assign bus.flowStop = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH = 64;
    localparam int HIGH  = 48;
    localparam int LOW   = 16;
`ifdef UART_FLOW_CTRL_EN
    localparam bit FLOW_ON = 1'b1;
`else
    localparam bit FLOW_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .HIGH_WATER(HIGH), .LOW_WATER(LOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] dutLog[$];
    int mOverflow;
    int mDrops;
    bit mFlow;

    typedef struct {
        logic       dr;
        logic [7:0] d;
        logic       rdy;
        logic       expValid;
        logic [7:0] expData;
        logic [6:0] expCount;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        q.delete();
        mOverflow = 0;
        mDrops    = 0;
        mFlow     = 1'b0;
    endtask

    task automatic checkModel();
        check("outValid", 32'(bus.outValid), 32'(q.size() > 0));
        if (q.size() > 0) check("outData", 32'(bus.outData), 32'(q[0]));
        check("count", 32'(bus.count), 32'(q.size()));
        check("overflow", 32'(bus.overflow), 32'(mOverflow));
        check("dropCount", 32'(bus.dropCount), 32'(mDrops));
        check("flowStop", 32'(bus.flowStop), 32'(mFlow));
    endtask

    // Called at a negedge: compare, drive one cycle, advance the model over the edge.
    task automatic step(input logic dr, input logic [7:0] d, input logic rdy, input bit doCheck = 1'b1);
        bit pop, push;
        if (doCheck) checkModel();
        bus.dataReady = dr;
        bus.data      = d;
        bus.outReady  = rdy;
        @(posedge clk);
        pop  = (q.size() > 0) && rdy;
        push = dr && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        if (dr && !push) begin
            mOverflow = 1;
            if (mDrops < 65535) mDrops++;
        end
        if (FLOW_ON) begin
            if (q.size() >= HIGH)     mFlow = 1'b1;
            else if (q.size() <= LOW) mFlow = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.dataReady = 1'b0;
        bus.outReady  = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        modelClear();
    endtask

    initial begin
        rst = 1'b0;
        bus.dataReady = 1'b0;
        bus.data      = '0;
        bus.outReady  = 1'b0;
        modelClear();

        vecs[0] = '{1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 7'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0};
        vecs[2] = '{1'b1, 8'h42, 1'b0, 1'b1, 8'h42, 7'd1};
        vecs[3] = '{1'b1, 8'h43, 1'b0, 1'b1, 8'h42, 7'd2};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 7'd2};
        vecs[5] = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h43, 7'd2};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 7'd1};
        vecs[7] = '{1'b1, 8'h45, 1'b1, 1'b1, 8'h45, 7'd1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 7'd0};

        repeat (2) @(negedge clk);
        check("rstOutValid", 32'(bus.outValid), 32'd0);
        check("rstOutData", 32'(bus.outData), 32'd0);
        check("rstCount", 32'(bus.count), 32'd0);
        check("rstOverflow", 32'(bus.overflow), 32'd0);
        check("rstDropCount", 32'(bus.dropCount), 32'd0);
        check("rstFlowStop", 32'(bus.flowStop), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table: latency, bypass, stall stability, push+pop in each state.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].dr, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), 32'(bus.outValid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) check($sformatf("vec%0d_data", i), 32'(bus.outData), 32'(vecs[i].expData));
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].expCount));
        end

        // Burst into a stalled parser, then drain with no bubble.
        doReset();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("burstCount", 32'(bus.count), 32'd64);
        check("burstHeld", 32'(bus.outData), 32'd0);
        for (int i = 0; i < 64; i++) begin
            check("burstValid", 32'(bus.outValid), 32'd1);
            check("burstData", 32'(bus.outData), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("burstEmpty", 32'(bus.outValid), 32'd0);

        // Overflow at full, then push with a simultaneous pop.
        doReset();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
        check("ovfFlag", 32'(bus.overflow), 32'd1);
        check("ovfDrops", 32'(bus.dropCount), 32'd3);
        check("ovfHead", 32'(bus.outData), 32'd0);
        step(1'b1, 8'hB0, 1'b1);
        check("ovfPushPopCount", 32'(bus.count), 32'd64);
        check("ovfPushPopDrops", 32'(bus.dropCount), 32'd3);
        dutLog.delete();
        for (int c = 0; c < 70; c++) begin
            if (bus.outValid) dutLog.push_back(bus.outData);
            step(1'b0, 8'h00, 1'b1);
        end
        check("ovfDrainLen", 32'(dutLog.size()), 32'd64);
        for (int k = 0; k < 64 && k < dutLog.size(); k++)
            check("ovfDrainByte", 32'(dutLog[k]), (k < 63) ? 32'(k + 1) : 32'hB0);

        // Asynchronous reset in the middle of a buffered stream.
        doReset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midRstCount", 32'(bus.count), 32'd0);
        check("midRstValid", 32'(bus.outValid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        modelClear();
        step(1'b1, 8'h55, 1'b0);
        check("postRstData", 32'(bus.outData), 32'h55);
        check("postRstCount", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1);

        // Flow-stop hysteresis thresholds.
        doReset();
        for (int i = 0; i < 47; i++) step(1'b1, 8'(i), 1'b0);
        check("flow47", 32'(bus.flowStop), 32'd0);
        step(1'b1, 8'd47, 1'b0);
        check("flow48", 32'(bus.flowStop), 32'(FLOW_ON));
        for (int i = 0; i < 31; i++) step(1'b0, 8'h00, 1'b1);
        check("flowDrain17", 32'(bus.flowStop), 32'(FLOW_ON));
        step(1'b0, 8'h00, 1'b1);
        check("flowDrain16", 32'(bus.flowStop), 32'd0);

        // Randomized traffic with varying push and accept densities.
        doReset();
        for (int p = 0; p < 8; p++) begin
            int pd;
            int pr;
            pd = int'($urandom_range(20, 100));
            pr = int'($urandom_range(0, 100));
            for (int c = 0; c < 400; c++)
                step(int'($urandom_range(0, 99)) < pd, 8'($urandom), int'($urandom_range(0, 99)) < pr);
        end
        checkModel();

        // Drop counter saturation.
        doReset();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b1, 8'(i), 1'b0, (i % 4096) == 0);
        check("satDrops", 32'(bus.dropCount), 32'hFFFF);
        check("satOverflow", 32'(bus.overflow), 32'd1);
        check("satCount", 32'(bus.count), 32'd64);
        check("satHead", 32'(bus.outData), 32'd0);
        checkModel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer between the asynchronous UART receiver and the VT100 parser.
- Absorbs receive bursts while the parser stalls (scroll, erase, text RAM writes).
- Converts the receiver's single-cycle strobe into a valid/ready stream for the parser.
- Runs in the 100 MHz parser domain and reports overflow so dropped characters are visible on the debug bus.

Parameters:
- DEPTH, 64: storage depth in bytes, including the output register. Power of two, ≥4.
- HIGH_WATER, 48: fill level at which flow stop asserts. Used only with the optional feature.
- LOW_WATER, 16: fill level at which flow stop releases. Must be < HIGH_WATER.

Ports:
- clk  in  1  system clock (100 MHz parser domain).
- rst  in  1  asynchronous, active-low reset.
- dataReady  in  1  single-cycle strobe from the UART receiver: a new byte is present.
- data  in  8  received byte, valid when dataReady=1.
- outValid  out  1  outData holds the oldest buffered byte.
- outData  out  8  oldest buffered byte (show-ahead).
- outReady  in  1  parser accepts outData this cycle.
- count  out  $clog2(DEPTH)+1  bytes currently held (0..DEPTH).
- overflow  out  1  sticky: at least one byte has been dropped since reset.
- dropCount  out  16  number of dropped bytes, saturating.
- flowStop  out  1  request that the host pause transmission.

Behaviour:
- Reset (rst=0, asynchronous): outValid=0, outData=0, count=0, overflow=0, dropCount=0, flowStop=0. Read and write pointers clear. Any byte in flight is discarded.
- Push: dataReady=1 and (count<DEPTH or a pop occurs in the same cycle) → byte stored.
- Pop: outValid=1 and outReady=1 → byte consumed. The next byte, if any, is presented on the following cycle with no bubble.
- Latency: on an empty FIFO, a byte pushed in cycle N gives outValid=1 with outData=byte in cycle N+1. No combinational path from dataReady to outValid.
- Stability: while outValid=1 and outReady=0, outData and outValid hold unchanged.
- outReady while outValid=0 is ignored.
- Ordering: strict FIFO order, no reordering or duplication.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop. Registered, reflecting the state after the previous edge.
- Full (count=DEPTH):
  - Push with a simultaneous pop is accepted.
  - Push without a pop is dropped: overflow←1, dropCount←dropCount+1, saturating at 16'hFFFF.
  - Stored contents are unaffected.
- Empty and simultaneous push (count=0): the byte goes straight to the output register. No pop is possible that cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, not pointer equality.
- overflow and dropCount clear only on reset.
- Storage uses a synchronous-read RAM plus an output register. The prefetch state machine is:
  - EMPTY → output register loaded directly from a push.
  - PRIMED → output valid, RAM holds 0 bytes.
  - STREAMING → output valid, RAM holds ≥1 byte, next byte is read ahead.
  - Transitions follow push/pop events. The RAM read is issued in the same cycle as a pop so the next byte arrives without a bubble.

Optional Feature:
- Macro: UART_FLOW_CTRL_EN.
- Defined:
  - flowStop←1 on the edge where count becomes ≥HIGH_WATER.
  - flowStop←0 when count becomes ≤LOW_WATER.
  - Between the two levels, flowStop holds its value (hysteresis).
  - The transmit path uses flowStop to send XOFF/XON.
- Undefined: flowStop is tied to 0, and the HIGH_WATER and LOW_WATER comparators are not synthesised.

Decomposition:
- Shared package (DataType.svh):
  - UartByte_t (logic[7:0]).
  - UART_FIFO_DEPTH default constant.
  - UartStream_t struct {valid, data} for the parser-side stream.
- Sub-module byte_fifo_ram: simple dual-port RAM, DEPTH×8, one write port, one synchronous-read port, no reset on contents.
- Pointers, count, prefetch state machine and flow control stay in uart_rx_fifo.

Test Plan:
- Reset mid-stream: 10 bytes buffered, then rst pulsed low asynchronously → count=0, outValid=0 immediately. Bytes pushed after release start from the first new byte.
- Single byte: push 8'h41 with outReady=1 → outValid=1 for exactly one cycle, one cycle after the strobe, outData=8'h41, count returns to 0.
- Burst with a stalled parser: push 0x00..0x3F back-to-back, outReady=0 → count=64, outData=0x00 held stable. Then outReady=1 continuously → 0x00..0x3F delivered one per cycle with no bubble.
- Overflow: fill to 64, push 3 more (0xA0..0xA2) → overflow=1, dropCount=3, and the drained sequence excludes 0xA0..0xA2. Then push at full with a simultaneous pop → accepted, count stays 64, dropCount stays 3.
- Saturation: force 70000 drops → dropCount=16'hFFFF, no wrap.
- UART_FLOW_CTRL_EN defined:
  - Fill to 47 → flowStop=0; 48th byte → flowStop=1.
  - Drain to 17 → flowStop=1; drain to 16 → flowStop=0.
  - Macro undefined, same stimulus → flowStop=0 throughout.
